// File: rtl/pri_arb_pkg.sv
// Shared types and constants for the eight-way priority / round-robin arbiter.
package pri_arb_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned ID_W  = 3;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;

  typedef logic [ID_W-1:0] arb_id_t;

  function automatic int unsigned hold_cnt_w(input int unsigned max_hold);
    return (max_hold == 0) ? 1 : $clog2(max_hold + 1);
  endfunction

endpackage

// File: rtl/pri_arbiter_8_rr_pri_sel.sv
// Combinational winner select: rotate candidates by last_id, highest-index
// priority encode, then un-rotate the index back to a requester number.
module rr_pri_sel
  import pri_arb_pkg::*;
(
  input  logic [N_REQ-1:0] eff_i,
  input  arb_id_t          last_id_i,
  input  logic             rr_en_i,
  output logic             any_o,
  output arb_id_t          win_id_o
);

  arb_id_t          offset;
  arb_id_t          rot_win;
  logic [N_REQ-1:0] rot;

  always_comb begin
    offset = rr_en_i ? last_id_i : '0;
    // rot[7] maps to last_id-1, rot[0] to last_id itself (lowest priority).
    for (int unsigned j = 0; j < N_REQ; j++) begin
      rot[j] = eff_i[arb_id_t'(ID_W'(j) + offset)];
    end
    rot_win = '0;
    for (int unsigned j = 0; j < N_REQ; j++) begin
      if (rot[j]) rot_win = ID_W'(j);
    end
    any_o    = |eff_i;
    win_id_o = rot_win + offset;
  end

endmodule

// File: rtl/pri_arbiter_8.sv
// Eight-requester arbiter: grant FSM, hold-timeout counter and registered
// one-hot / binary grant outputs.
module pri_arbiter_8
  import pri_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_REQ-1:0] req_i,
  input  logic [N_REQ-1:0] mask_i,
  input  logic             rr_en_i,
  input  logic             done_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]  gnt_id_o,
  output logic             gnt_vld_o,
  output logic             timeout_o
);

  localparam int unsigned CNT_W = hold_cnt_w(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  arb_id_t          gnt_id_q, gnt_id_d;
  logic             gnt_vld_q, gnt_vld_d;
  logic             timeout_q, timeout_d;
  arb_id_t          last_id_q, last_id_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  logic [N_REQ-1:0] eff;
  logic             any;
  arb_id_t          win_id;
  logic             release_now;

  assign eff = req_i & mask_i;

  rr_pri_sel u_sel (
    .eff_i     (eff),
    .last_id_i (last_id_q),
    .rr_en_i   (rr_en_i),
    .any_o     (any),
    .win_id_o  (win_id)
  );

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_vld_d   = gnt_vld_q;
    timeout_d   = 1'b0;
    last_id_d   = last_id_q;
    hold_cnt_d  = hold_cnt_q;
    release_now = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (any) begin
          state_d        = ARB_BUSY;
          gnt_d          = '0;
          gnt_d[win_id]  = 1'b1;
          gnt_id_d       = win_id;
          gnt_vld_d      = 1'b1;
          hold_cnt_d     = '0;
          last_id_d      = win_id;
        end
      end
      ARB_BUSY: begin
        if (!req_i[gnt_id_q] || done_i) begin
          release_now = 1'b1;
        end else if ((MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST)) begin
          release_now = 1'b1;
          timeout_d   = 1'b1;
        end else if (hold_cnt_q != '1) begin
          // Saturating only matters with the timeout disabled.
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
        if (release_now) begin
          state_d    = ARB_IDLE;
          gnt_d      = '0;
          gnt_id_d   = '0;
          gnt_vld_d  = 1'b0;
          hold_cnt_d = '0;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ARB_IDLE;
      gnt_q      <= '0;
      gnt_id_q   <= '0;
      gnt_vld_q  <= 1'b0;
      timeout_q  <= 1'b0;
      last_id_q  <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      gnt_vld_q  <= gnt_vld_d;
      timeout_q  <= timeout_d;
      last_id_q  <= last_id_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign gnt_id_o  = gnt_id_q;
  assign gnt_vld_o = gnt_vld_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_pri_arbiter_8.sv
// Self-checking bench for pri_arbiter_8: table of per-cycle vectors plus
// hand-written timeout and reset sequences, checked through a queue.
module tb_pri_arbiter_8;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [7:0] req_i = '0;
  logic [7:0] mask_i = 8'hFF;
  logic       rr_en_i = 1'b0;
  logic       done_i = 1'b0;
  logic [7:0] gnt_o;
  logic [2:0] gnt_id_o;
  logic       gnt_vld_o;
  logic       timeout_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  pri_arbiter_8 #(.MAX_HOLD(16)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (req_i),
    .mask_i    (mask_i),
    .rr_en_i   (rr_en_i),
    .done_i    (done_i),
    .gnt_o     (gnt_o),
    .gnt_id_o  (gnt_id_o),
    .gnt_vld_o (gnt_vld_o),
    .timeout_o (timeout_o)
  );

  typedef struct {
    string      name;
    logic       rst;
    logic [7:0] req;
    logic [7:0] mask;
    logic       rr;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] id;
    logic       vld;
    logic       to;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] gnt;
    logic [2:0] id;
    logic       vld;
    logic       to;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  function automatic vec_t mk(input string nm, input logic rst, input logic [7:0] req,
                              input logic [7:0] mask, input logic rr, input logic done,
                              input logic [7:0] gnt, input logic [2:0] id,
                              input logic vld, input logic to);
    vec_t v;
    v.name = nm; v.rst = rst; v.req = req; v.mask = mask; v.rr = rr; v.done = done;
    v.gnt = gnt; v.id = id; v.vld = vld; v.to = to;
    return v;
  endfunction

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic step(input vec_t v);
    exp_t e;
    @(negedge clk_i);
    rst_i = v.rst; req_i = v.req; mask_i = v.mask; rr_en_i = v.rr; done_i = v.done;
    e.name = v.name; e.gnt = v.gnt; e.id = v.id; e.vld = v.vld; e.to = v.to;
    sb.push_back(e);
    @(posedge clk_i);
    #1;
    e = sb.pop_front();
    n_tests++;
    if (gnt_o !== e.gnt || gnt_id_o !== e.id || gnt_vld_o !== e.vld || timeout_o !== e.to) begin
      n_fail++;
      $display("FAIL %s: got gnt=%h id=%0d vld=%b to=%b, expected gnt=%h id=%0d vld=%b to=%b",
               e.name, gnt_o, gnt_id_o, gnt_vld_o, timeout_o, e.gnt, e.id, e.vld, e.to);
    end
  endtask

  task automatic check_val(input string nm, input int act, input int exp_v);
    n_tests++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
    end
  endtask

  initial begin
    logic [2:0] id;
    int         vld_cycles;
    logic       to_seen;
    logic [7:0] gnt_at_to;

    // Fixed priority, hold, owner drop and turnaround bubble.
    tbl.push_back(mk("rst",        1, 8'h00, 8'hFF, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk("t1_grant",   0, 8'hA4, 8'hFF, 0, 0, 8'h80, 7, 1, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk("t1_hold",  0, 8'hA4, 8'hFF, 0, 0, 8'h80, 7, 1, 0));
    tbl.push_back(mk("t2_release", 0, 8'h24, 8'hFF, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk("t2_regrant", 0, 8'h24, 8'hFF, 0, 0, 8'h20, 5, 1, 0));
    tbl.push_back(mk("t2_mask_ign",0, 8'h24, 8'h00, 1, 0, 8'h20, 5, 1, 0));
    tbl.push_back(mk("t2_done",    0, 8'h24, 8'hFF, 0, 1, 8'h00, 0, 0, 0));

    // Round-robin rotation 7,6,...,0,7.
    tbl.push_back(mk("t3_rst",     1, 8'h00, 8'hFF, 1, 0, 8'h00, 0, 0, 0));
    for (int k = 0; k < 9; k++) begin
      id = 3'(7 - k);
      tbl.push_back(mk($sformatf("t3_grant%0d", k), 0, 8'hFF, 8'hFF, 1, 0,
                       8'(1) << id, id, 1, 0));
      tbl.push_back(mk("t3_done",  0, 8'hFF, 8'hFF, 1, 1, 8'h00, 0, 0, 0));
    end

    // Mask blocking, then done coinciding with the timeout edge.
    tbl.push_back(mk("t5_masked",  0, 8'h01, 8'hFE, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk("t5_masked",  0, 8'h01, 8'hFE, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk("t5_unmask",  0, 8'h01, 8'hFF, 0, 0, 8'h01, 0, 1, 0));
    for (int i = 0; i < 15; i++)
      tbl.push_back(mk("t5_hold",  0, 8'h01, 8'h00, 0, 0, 8'h01, 0, 1, 0));
    tbl.push_back(mk("t5_done_to", 0, 8'h01, 8'hFF, 0, 1, 8'h00, 0, 0, 0));
    tbl.push_back(mk("t5_idle",    0, 8'h00, 8'hFF, 0, 0, 8'h00, 0, 0, 0));

    foreach (tbl[i]) step(tbl[i]);

    // Forced release after MAX_HOLD cycles, then rotation past the old owner.
    step(mk("t4_rst",   1, 8'h00, 8'hFF, 1, 0, 8'h00, 0, 0, 0));
    step(mk("t4_grant", 0, 8'h08, 8'hFF, 1, 0, 8'h08, 3, 1, 0));
    vld_cycles = 1;
    to_seen    = 1'b0;
    gnt_at_to  = 8'hFF;
    for (int c = 0; c < 40 && !to_seen; c++) begin
      @(negedge clk_i);
      req_i = 8'h0C; done_i = 1'b0;
      @(posedge clk_i);
      #1;
      if (timeout_o) begin
        to_seen   = 1'b1;
        gnt_at_to = gnt_o;
      end else if (gnt_vld_o && gnt_id_o == 3'd3) begin
        vld_cycles++;
      end
    end
    check_val("t4_timeout_seen", int'(to_seen), 1);
    check_val("t4_vld_cycles", vld_cycles, 16);
    check_val("t4_gnt_at_timeout", int'(gnt_at_to), 0);
    step(mk("t4_next_rr", 0, 8'h0C, 8'hFF, 1, 0, 8'h04, 2, 1, 0));
    step(mk("t4_done",    0, 8'h0C, 8'hFF, 1, 1, 8'h00, 0, 0, 0));

    // Reset mid-grant clears last_id back to 0.
    step(mk("t6_grant",   0, 8'h10, 8'hFF, 0, 0, 8'h10, 4, 1, 0));
    step(mk("t6_hold",    0, 8'h10, 8'hFF, 0, 0, 8'h10, 4, 1, 0));
    step(mk("t6_rst",     1, 8'h10, 8'hFF, 0, 0, 8'h00, 0, 0, 0));
    step(mk("t6_rr_after",0, 8'h18, 8'hFF, 1, 0, 8'h10, 4, 1, 0));
    step(mk("t6_done",    0, 8'h18, 8'hFF, 1, 1, 8'h00, 0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
